// File: rtl/pid_pkg.sv
// Shared widths, FSM state and MAC term encodings for the multi-channel PID core.
package pid_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, UPDATE, DONE} state_t;
  typedef enum logic [2:0] {T_B0, T_B1, T_B2, T_A0, T_A1} term_t;

  function automatic int e_w(int adc_w);
    return adc_w + 1;
  endfunction

  function automatic int y_w(int adc_w, int guard);
    return adc_w + guard + 1;
  endfunction

  function automatic int op_w(int reg_w, int yw);
    return (reg_w > yw) ? reg_w : yw;
  endfunction

  function automatic int acc_w(int opw);
    return 2 * opw + 3;
  endfunction

endpackage

// File: rtl/pid_seq_mul.sv
// Radix-2 shift-add signed multiplier; bit 0 is consumed in the start cycle so
// done_o rises exactly W cycles after start_i.
module pid_seq_mul #(
  parameter int W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic signed [2*W-1:0] prod_o
);
  localparam int CNT_W = $clog2(W + 1);

  logic signed [2*W-1:0] mcand_q, prod_q;
  logic [W-1:0]          mplier_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last;

  // the final bit carries negative weight in two's complement
  assign last   = (cnt_q == CNT_W'(W - 1));
  assign prod_o = prod_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        prod_q   <= b_i[0] ? (2*W)'(a_i) : '0;
        mcand_q  <= (2*W)'(a_i) <<< 1;
        mplier_q <= b_i >> 1;
        cnt_q    <= CNT_W'(1);
        busy_o   <= 1'b1;
      end else if (busy_o) begin
        if (mplier_q[0]) prod_q <= last ? prod_q - mcand_q : prod_q + mcand_q;
        mcand_q  <= mcand_q <<< 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (last) begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pid_core_mc.sv
// Multi-channel IIR-form PID core sharing one sequential multiplier across channels.
// Optional macro PID_SAT_FLAG_EN adds per-channel saturation flags (sat_flag_o).
module pid_core_mc
  import pid_pkg::*;
#(
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 16,
  parameter int FRAC_BITWIDTH = 12,
  parameter int CHANNELS      = 2,
  parameter int GUARD_BITS    = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 clk_en_PID_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]     ADC_value_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]     SET_value_i,
  input  logic [CHANNELS*REG_BITWIDTH-1:0]     b0_reg_i,
  input  logic [CHANNELS*REG_BITWIDTH-1:0]     b1_reg_i,
  input  logic [CHANNELS*REG_BITWIDTH-1:0]     b2_reg_i,
  input  logic [CHANNELS*REG_BITWIDTH-1:0]     a0_reg_i,
  input  logic [CHANNELS*REG_BITWIDTH-1:0]     a1_reg_i,
  output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0] out_Val_o,
  output logic                                 busy_o,
  output logic                                 done_strb_o,
  output logic                                 overrun_o
`ifdef PID_SAT_FLAG_EN
  ,
  output logic [CHANNELS-1:0]                  sat_flag_o
`endif
);
  localparam int E_W   = e_w(ADC_BITWIDTH);
  localparam int Y_W   = y_w(ADC_BITWIDTH, GUARD_BITS);
  localparam int OP_W  = op_w(REG_BITWIDTH, Y_W);
  localparam int ACC_W = acc_w(OP_W);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic signed [ACC_W-1:0] Y_HI = {{(ACC_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_LO = ~Y_HI;
  localparam logic signed [Y_W-1:0]   O_HI = {{(Y_W-ADC_BITWIDTH){1'b0}}, {ADC_BITWIDTH{1'b1}}};
  localparam logic signed [Y_W-1:0]   O_LO = ~O_HI;

  logic [CHANNELS-1:0][ADC_BITWIDTH-1:0] adc_q, set_q;
  logic [CHANNELS-1:0][REG_BITWIDTH-1:0] b0_q, b1_q, b2_q, a0_q, a1_q;
  logic [CHANNELS-1:0][E_W-1:0]          e1_q, e2_q, out_q;
  logic [CHANNELS-1:0][Y_W-1:0]          y1_q, y2_q;

  state_t                  state_q, state_d;
  term_t                   term_q;
  logic [CH_W-1:0]         ch_q;
  logic                    last_ch;
  logic signed [E_W-1:0]   e_q;
  logic signed [ACC_W-1:0] acc_q;

  logic                    mul_start, mul_busy, mul_done, sub_term;
  logic signed [OP_W-1:0]  op_a, op_b;
  logic signed [2*OP_W-1:0] mul_prod;
  logic signed [ACC_W-1:0] prod_x, y_full;
  logic signed [Y_W-1:0]   y_sat;
  logic signed [E_W-1:0]   o_sat;
  logic                    clip_y, clip_o;

  assign last_ch     = (ch_q == CH_W'(CHANNELS - 1));
  assign busy_o      = (state_q == LOAD) || (state_q == MAC) || (state_q == UPDATE);
  assign done_strb_o = (state_q == DONE);
  assign overrun_o   = clk_en_PID_i && (state_q != IDLE);
  assign out_Val_o   = out_q;
  assign prod_x      = ACC_W'(mul_prod);
  // a new term is launched in the cycle after the previous product lands
  assign mul_start   = (state_q == MAC) && !mul_busy && !mul_done;

  always_comb begin
    op_a     = '0;
    op_b     = '0;
    sub_term = 1'b0;
    case (term_q)
      T_B0: begin op_a = OP_W'($signed(b0_q[ch_q])); op_b = OP_W'(e_q); end
      T_B1: begin op_a = OP_W'($signed(b1_q[ch_q])); op_b = OP_W'($signed(e1_q[ch_q])); end
      T_B2: begin op_a = OP_W'($signed(b2_q[ch_q])); op_b = OP_W'($signed(e2_q[ch_q])); end
      T_A0: begin op_a = OP_W'($signed(a0_q[ch_q])); op_b = OP_W'($signed(y1_q[ch_q])); sub_term = 1'b1; end
      T_A1: begin op_a = OP_W'($signed(a1_q[ch_q])); op_b = OP_W'($signed(y2_q[ch_q])); sub_term = 1'b1; end
      default: ;
    endcase
  end

  pid_seq_mul #(.W(OP_W)) u_mul (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .start_i(mul_start),
    .a_i    (op_a),
    .b_i    (op_b),
    .busy_o (mul_busy),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  // two-stage clip: history range first, then the narrower output range
  always_comb begin
    y_full = acc_q >>> FRAC_BITWIDTH;
    y_sat  = y_full[Y_W-1:0];
    o_sat  = y_sat[E_W-1:0];
    clip_y = 1'b0;
    clip_o = 1'b0;
    if (y_full > Y_HI) begin
      y_sat  = Y_HI[Y_W-1:0];
      clip_y = 1'b1;
    end else if (y_full < Y_LO) begin
      y_sat  = Y_LO[Y_W-1:0];
      clip_y = 1'b1;
    end
    if (y_sat > O_HI) begin
      o_sat  = O_HI[E_W-1:0];
      clip_o = 1'b1;
    end else if (y_sat < O_LO) begin
      o_sat  = O_LO[E_W-1:0];
      clip_o = 1'b1;
    end else begin
      o_sat  = y_sat[E_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clk_en_PID_i) state_d = LOAD;
      LOAD:    state_d = MAC;
      MAC:     if (mul_done && term_q == T_A1) state_d = UPDATE;
      UPDATE:  state_d = last_ch ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      adc_q  <= '0; set_q <= '0;
      b0_q   <= '0; b1_q  <= '0; b2_q <= '0; a0_q <= '0; a1_q <= '0;
      e1_q   <= '0; e2_q  <= '0; y1_q <= '0; y2_q <= '0; out_q <= '0;
      e_q    <= '0; acc_q <= '0;
      ch_q   <= '0; term_q <= T_B0;
    end else begin
      case (state_q)
        IDLE: if (clk_en_PID_i) begin
          adc_q <= ADC_value_i; set_q <= SET_value_i;
          b0_q  <= b0_reg_i; b1_q <= b1_reg_i; b2_q <= b2_reg_i;
          a0_q  <= a0_reg_i; a1_q <= a1_reg_i;
          ch_q  <= '0;
        end
        LOAD: begin
          e_q    <= $signed({1'b0, set_q[ch_q]}) - $signed({1'b0, adc_q[ch_q]});
          acc_q  <= '0;
          term_q <= T_B0;
        end
        MAC: if (mul_done) begin
          acc_q <= sub_term ? acc_q - prod_x : acc_q + prod_x;
          if (term_q != T_A1) term_q <= term_t'(term_q + 3'd1);
        end
        UPDATE: begin
          e2_q[ch_q]  <= e1_q[ch_q];
          e1_q[ch_q]  <= e_q;
          y2_q[ch_q]  <= y1_q[ch_q];
          y1_q[ch_q]  <= y_sat;
          out_q[ch_q] <= o_sat;
          if (!last_ch) ch_q <= ch_q + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PID_SAT_FLAG_EN
  logic [CHANNELS-1:0] sat_q;
  assign sat_flag_o = sat_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 sat_q       <= '0;
    else if (state_q == UPDATE)  sat_q[ch_q] <= clip_y | clip_o;
  end
`endif

endmodule

// File: tb/tb_pid_core_mc.sv
// Randomized and directed checks of pid_core_mc against a plain-arithmetic PID model.
module tb_pid_core_mc;
  localparam int CH  = 2;
  localparam int AW  = 8;
  localparam int RW  = 16;
  localparam int FW  = 12;
  localparam int GB  = 3;
  localparam int EW  = AW + 1;
  localparam int YW  = AW + GB + 1;
  localparam int OPW = (RW > YW) ? RW : YW;
  localparam int LAT = 1 + CH * (1 + 5 * (OPW + 1) + 1);

  logic clk = 1'b0, rstn = 1'b0, strobe = 1'b0;
  logic [CH*AW-1:0] adc_v = '0, set_v = '0;
  logic [CH*RW-1:0] b0_v = '0, b1_v = '0, b2_v = '0, a0_v = '0, a1_v = '0;
  logic [CH*EW-1:0] out_v;
  logic busy, done, ovr;
`ifdef PID_SAT_FLAG_EN
  logic [CH-1:0] sat_v;
`endif

  int checks = 0, errors = 0;
  int set_a[CH], adc_a[CH], c_b0[CH], c_b1[CH], c_b2[CH], c_a0[CH], c_a1[CH];
  longint m_e1[CH], m_e2[CH], m_y1[CH], m_y2[CH];
  int exp_out[CH], prev_out[CH];
  bit exp_sat[CH];

  always #5 clk = ~clk;

  pid_core_mc #(.ADC_BITWIDTH(AW), .REG_BITWIDTH(RW), .FRAC_BITWIDTH(FW),
                .CHANNELS(CH), .GUARD_BITS(GB)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_PID_i(strobe),
    .ADC_value_i(adc_v), .SET_value_i(set_v),
    .b0_reg_i(b0_v), .b1_reg_i(b1_v), .b2_reg_i(b2_v), .a0_reg_i(a0_v), .a1_reg_i(a1_v),
    .out_Val_o(out_v), .busy_o(busy), .done_strb_o(done), .overrun_o(ovr)
`ifdef PID_SAT_FLAG_EN
    , .sat_flag_o(sat_v)
`endif
  );

  function automatic int out_ch(int c);
    return int'($signed(out_v[c*EW +: EW]));
  endfunction

  function automatic longint clip(longint v, longint lo, longint hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic apply_inputs();
    for (int c = 0; c < CH; c++) begin
      adc_v[c*AW +: AW] = AW'(adc_a[c]);
      set_v[c*AW +: AW] = AW'(set_a[c]);
      b0_v[c*RW +: RW]  = RW'(c_b0[c]);
      b1_v[c*RW +: RW]  = RW'(c_b1[c]);
      b2_v[c*RW +: RW]  = RW'(c_b2[c]);
      a0_v[c*RW +: RW]  = RW'(c_a0[c]);
      a1_v[c*RW +: RW]  = RW'(c_a1[c]);
    end
  endtask

  task automatic set_chan(int c, int s, int a, int b0, int b1, int b2, int a0, int a1);
    set_a[c] = s; adc_a[c] = a;
    c_b0[c] = b0; c_b1[c] = b1; c_b2[c] = b2; c_a0[c] = a0; c_a1[c] = a1;
  endtask

  task automatic randomize_inputs();
    for (int c = 0; c < CH; c++)
      set_chan(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 8191)) - 4096,
               int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 8191)) - 4096,
               int'($urandom_range(0, 4095)) - 2048);
    apply_inputs();
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
      exp_out[c] = 0; prev_out[c] = 0; exp_sat[c] = 0;
    end
  endtask

  // one sample of y = b0 e + b1 e1 + b2 e2 - a0 y1 - a1 y2, scaled and clipped
  task automatic model_step();
    longint e, acc, y, ys, o;
    for (int c = 0; c < CH; c++) begin
      e   = longint'(set_a[c]) - longint'(adc_a[c]);
      acc = c_b0[c] * e + c_b1[c] * m_e1[c] + c_b2[c] * m_e2[c]
          - c_a0[c] * m_y1[c] - c_a1[c] * m_y2[c];
      y   = acc >>> FW;
      ys  = clip(y, -(64'sd1 <<< (YW - 1)), (64'sd1 <<< (YW - 1)) - 1);
      o   = clip(ys, -(64'sd1 <<< AW), (64'sd1 <<< AW) - 1);
      exp_sat[c]  = (ys != y) || (o != ys);
      prev_out[c] = exp_out[c];
      exp_out[c]  = int'(o);
      m_e2[c] = m_e1[c]; m_e1[c] = e;
      m_y2[c] = m_y1[c]; m_y1[c] = ys;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0; strobe = 1'b0;
    @(negedge clk); rstn = 1'b1;
    model_reset();
  endtask

  task automatic run_strobe(string tag, bit perturb);
    int k;
    @(negedge clk); strobe = 1'b1; model_step();
    @(negedge clk); strobe = 1'b0; k = 1;
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (out_ch(c) !== prev_out[c]) begin
        errors++; $display("FAIL %s hold ch%0d: got %0d expected %0d", tag, c, out_ch(c), prev_out[c]);
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b expected 1", tag, busy); end
    while (done !== 1'b1 && k < LAT + 50) begin
      @(negedge clk); k++;
      if (perturb && k == 60) randomize_inputs();
      if (k == 100) begin
        checks++;
        if (out_ch(0) !== exp_out[0] || out_ch(1) !== prev_out[1]) begin
          errors++;
          $display("FAIL %s mid ch0/ch1: got %0d/%0d expected %0d/%0d", tag,
                   out_ch(0), out_ch(1), exp_out[0], prev_out[1]);
        end
      end
    end
    checks++;
    if (k !== LAT) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, k, LAT); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy at done: got %b expected 0", tag, busy); end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (out_ch(c) !== exp_out[c]) begin
        errors++; $display("FAIL %s out ch%0d: got %0d expected %0d", tag, c, out_ch(c), exp_out[c]);
      end
`ifdef PID_SAT_FLAG_EN
      checks++;
      if (sat_v[c] !== exp_sat[c]) begin
        errors++; $display("FAIL %s sat ch%0d: got %b expected %b", tag, c, sat_v[c], exp_sat[c]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_v !== '0 || busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
      errors++; $display("FAIL reset state: got out=%h busy=%b done=%b ovr=%b expected all 0", out_v, busy, done, ovr);
    end
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_proportional();
    do_reset();
    set_chan(0, 100, 40, 4096, 0, 0, 0, 0);
    set_chan(1, 0, 200, 4096, 0, 0, 0, 0);
    apply_inputs();
    run_strobe("prop", 1'b0);
    checks++;
    if (out_ch(0) !== 60 || out_ch(1) !== -200) begin
      errors++; $display("FAIL prop const: got %0d/%0d expected 60/-200", out_ch(0), out_ch(1));
    end
  endtask

  task automatic test_integrator();
    int want;
    do_reset();
    for (int c = 0; c < CH; c++) set_chan(c, 10, 0, 4096, 0, 0, -4096, 0);
    apply_inputs();
    for (int n = 1; n <= 30; n++) begin
      run_strobe("integ", 1'b0);
      want = (10 * n > 255) ? 255 : 10 * n;
      checks++;
      if (out_ch(0) !== want) begin
        errors++; $display("FAIL integ step %0d: got %0d expected %0d", n, out_ch(0), want);
      end
`ifdef PID_SAT_FLAG_EN
      checks++;
      if (sat_v[0] !== (n >= 26)) begin
        errors++; $display("FAIL integ flag step %0d: got %b expected %b", n, sat_v[0], n >= 26);
      end
`endif
    end
  endtask

  task automatic test_neg_clip();
    do_reset();
    for (int c = 0; c < CH; c++) set_chan(c, 0, 255, 8192, 0, 0, 0, 0);
    apply_inputs();
    run_strobe("negclip", 1'b0);
    checks++;
    if (out_ch(0) !== -256) begin
      errors++; $display("FAIL negclip const: got %0d expected -256", out_ch(0));
    end
  endtask

  task automatic test_overrun();
    int n_ovr = 0, n_done = 0;
    bit busy_bad = 1'b0;
    do_reset();
    set_chan(0, 100, 40, 4096, 0, 0, 0, 0);
    set_chan(1, 0, 200, 4096, 0, 0, 0, 0);
    apply_inputs();
    @(negedge clk); strobe = 1'b1; model_step();
    #1 if (ovr) n_ovr++;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      strobe = (k == 50 || k == LAT);
      #1;
      if (ovr)  n_ovr++;
      if (done) n_done++;
      if (k > LAT && busy) busy_bad = 1'b1;
    end
    strobe = 1'b0;
    checks++;
    if (n_ovr !== 2) begin errors++; $display("FAIL overrun count: got %0d expected 2", n_ovr); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL overrun done count: got %0d expected 1", n_done); end
    checks++;
    if (busy_bad !== 1'b0) begin errors++; $display("FAIL overrun restart: got busy expected idle"); end
    checks++;
    if (out_ch(0) !== 60 || out_ch(1) !== -200) begin
      errors++; $display("FAIL overrun out: got %0d/%0d expected 60/-200", out_ch(0), out_ch(1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < CH; c++) set_chan(c, 10, 0, 4096, 0, 0, -4096, 0);
    apply_inputs();
    run_strobe("rstmid pre", 1'b0);
    @(negedge clk); strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (99) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (out_v !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid abort: got out=%h busy=%b expected 0", out_v, busy);
    end
    @(negedge clk); rstn = 1'b1;
    model_reset();
    run_strobe("rstmid post", 1'b0);
    checks++;
    if (out_ch(0) !== 10) begin
      errors++; $display("FAIL rstmid restart: got %0d expected 10", out_ch(0));
    end
  endtask

  task automatic test_independence();
    do_reset();
    set_chan(0, 255, 0, 4096, 0, 0, -4096, 0);
    set_chan(1, 5, 0, 4096, 0, 0, 0, 0);
    apply_inputs();
    for (int n = 0; n < 12; n++) begin
      run_strobe("indep", 1'b0);
      checks++;
      if (out_ch(1) !== 5) begin
        errors++; $display("FAIL indep ch1 step %0d: got %0d expected 5", n, out_ch(1));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 10; n++) begin
      randomize_inputs();
      run_strobe("random", n[0]);
    end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integrator();
    test_neg_clip();
    test_overrun();
    test_reset_mid();
    test_independence();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_core_mc.md
Name: pid_core_mc

Overview:
- Multi-channel successor to the single-channel PID core.
- Evaluates CHANNELS independent IIR-form PID laws per sample strobe: y[n] = b0*e[n] + b1*e[n-1] + b2*e[n-2] - a0*y[n-1] - a1*y[n-2].
- One shared sequential signed multiplier is time-multiplexed over all channels.
- Adds per-channel coefficients, busy/done handshake, overrun detection and two-level saturation.
- Sits between the ADC/setpoint registers and the PWM output stage of the fan controller.

Parameters:
- ADC_BITWIDTH, 8, width of unsigned ADC and setpoint samples.
- REG_BITWIDTH, 16, signed coefficient width, fixed-point Q(REG_BITWIDTH-FRAC_BITWIDTH).FRAC_BITWIDTH.
- FRAC_BITWIDTH, 12, fractional bits of the coefficients.
- CHANNELS, 2, number of independent control loops, 1..8.
- GUARD_BITS, 3, extra integer headroom for the stored output history.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- clk_en_PID_i  in  1  sample strobe, single-cycle.
- ADC_value_i  in  CHANNELS*ADC_BITWIDTH  packed measured values, channel 0 in the LSBs.
- SET_value_i  in  CHANNELS*ADC_BITWIDTH  packed setpoints.
- b0_reg_i, b1_reg_i, b2_reg_i, a0_reg_i, a1_reg_i  in  CHANNELS*REG_BITWIDTH each  packed signed coefficients.
- out_Val_o  out  CHANNELS*(ADC_BITWIDTH+1)  packed signed saturated outputs.
- busy_o  out  1  high while a sequence runs.
- done_strb_o  out  1  single-cycle pulse after the last channel has updated.
- overrun_o  out  1  single-cycle pulse when a strobe arrives while busy.

Behaviour:
- Widths:
  - E_W = ADC_BITWIDTH+1. e = SET-ADC, exact, in [-(2^ADC_BITWIDTH-1), 2^ADC_BITWIDTH-1].
  - Y_W = ADC_BITWIDTH+GUARD_BITS+1.
  - OP_W = max(REG_BITWIDTH, Y_W).
  - ACC_W = 2*OP_W+3.
- Reset, asynchronous: all histories e1, e2, y1, y2 = 0; out_Val_o = 0; busy_o, done_strb_o, overrun_o = 0; FSM in IDLE.
- FSM states and transitions:
  - IDLE: on clk_en_PID_i, latch all ADC/SET values and coefficients, go to LOAD, busy_o = 1.
  - LOAD, 1 cycle: compute e for the current channel; clear the accumulator.
  - MAC, 5 terms in order b0*e, b1*e1, b2*e2, -a0*y1, -a1*y2:
    - Pulse the multiplier start.
    - The multiplier returns done exactly OP_W cycles later.
    - Accumulate on done.
    - The next term starts on the following cycle, so each term takes OP_W+1 cycles.
  - UPDATE, 1 cycle:
    - y = acc >>> FRAC_BITWIDTH, arithmetic shift, truncation toward -inf.
    - Saturate y to the signed Y_W range.
    - Shift histories: e2<=e1, e1<=e, y2<=y1, y1<=y.
    - out_Val_o[ch] = y saturated to [-2^ADC_BITWIDTH, 2^ADC_BITWIDTH-1].
    - If ch < CHANNELS-1: increment ch, go to LOAD. Otherwise go to DONE.
  - DONE, 1 cycle: done_strb_o = 1, busy_o = 0, go to IDLE.
- Latency from strobe to done_strb_o: 1 + CHANNELS*(1+5*(OP_W+1)+1) cycles. Defaults: 1+2*87 = 175.
- out_Val_o[ch] changes only in that channel's UPDATE cycle and holds otherwise.
- Strobe in any state other than IDLE: ignored, overrun_o pulses in the same cycle as the strobe, the running sequence is unaffected.
- Strobe in the DONE cycle counts as overrun.
- Coefficient or input changes during a sequence have no effect until the next strobe.
- Reset asserted mid-sequence: immediate abort, no partial history update survives.
- Channels are fully independent; one channel saturating has no effect on any other channel.

Optional Feature:
- Macro: PID_SAT_FLAG_EN.
- With it defined:
  - Adds output sat_flag_o, CHANNELS bits wide.
  - Bit ch is set in that channel's UPDATE cycle if either saturation stage clipped y; otherwise it is cleared in that cycle.
  - Reset value 0.
- Without it: the port is absent, and saturation is silent.

Decomposition:
- Shared package pid_pkg holds:
  - width constants/functions E_W, Y_W, OP_W, ACC_W;
  - the FSM state encoding IDLE/LOAD/MAC/UPDATE/DONE;
  - the MAC term index encoding 0..4.
- One sub-module, pid_seq_mul:
  - radix-2 shift-add signed OP_W x OP_W multiplier;
  - start/done strobes, done exactly OP_W cycles after start;
  - 2*OP_W product; operands registered at start.

Test Plan:
- Proportional gain, CHANNELS=2, b0=4096 (1.0), all others 0:
  - ch0 SET=100/ADC=40, ch1 SET=0/ADC=200.
  - Result: out ch0=60, ch1=-200; done_strb_o exactly 175 cycles after the strobe.
- Integrator, b0=4096, a0=-4096, SET=10, ADC=0:
  - Result: out 10, 20, 30, ... per strobe; clamps at 255 from strobe 26 onward.
  - With PID_SAT_FLAG_EN: sat_flag_o[0]=1 from the first clamped strobe.
- Negative clip, b0=8192 (2.0), SET=0, ADC=255:
  - Result: out=-256, no wrap.
- Overrun: second strobe 50 cycles after the first.
  - Result: overrun_o pulses once, outputs equal the single-strobe result, done_strb_o pulses once.
- Reset mid-sequence: assert rstn_i at cycle 100 of the integrator test, then re-strobe.
  - Result: all outputs 0 immediately; after re-strobe out=10, confirming histories were cleared.
- Channel independence: ch0 driven into saturation, ch1 b0=4096 with e=5.
  - Result: ch1 out=5 on every strobe.
